// File: rtl/car_park_pkg.sv
// rtl/car_park_pkg.sv - shared encodings and widths for the car-park lab stimulus path
package car_park_pkg;

    localparam int OCC_W  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        CMD_ENTER = 2'b00,
        CMD_EXIT  = 2'b01,
        CMD_BALK  = 2'b10,
        CMD_GAP   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PH1     = 3'd1,
        ST_PH2     = 3'd2,
        ST_PH3     = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Returns {sensor_a, sensor_b} shown while in a given phase of a given command.
    function automatic logic [1:0] sensor_pattern(input state_e st, input cmd_e c);
        logic [1:0] p;
        p = 2'b00;
        case (st)
            ST_PH1: begin
                case (c)
                    CMD_ENTER, CMD_BALK: p = 2'b10;
                    CMD_EXIT:            p = 2'b01;
                    default:             p = 2'b00;
                endcase
            end
            ST_PH2: begin
                if (c != CMD_GAP) begin
                    p = 2'b11;
                end
            end
            ST_PH3: begin
                case (c)
                    CMD_ENTER:          p = 2'b01;
                    CMD_EXIT, CMD_BALK: p = 2'b10;
                    default:            p = 2'b00;
                endcase
            end
            default: p = 2'b00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase hold timer, flags the last cycle of a sensor phase
module phase_timer
    import car_park_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    logic [HOLD_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= HOLD_W'(HOLD_CYCLES - 1);
        end else if (r_count != '0) begin
            r_count <= r_count - HOLD_W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/car_stimulus_gen.sv
// rtl/car_stimulus_gen.sv - replays two-beam car crossings and expected-count pulses
module car_stimulus_gen
    import car_park_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_CARS    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             sensor_a,
    output logic             sensor_b,
    output logic             inc_exp,
    output logic             dec_exp,
    output logic             cmd_rejected,
    output logic [OCC_W-1:0] occ_count
);

    state_e           r_state;
    cmd_e             r_cmd;
    logic             r_rejected;
    logic             r_cmd_ready;
    logic             r_sensor_a;
    logic             r_sensor_b;
    logic             r_inc;
    logic             r_dec;
    logic             r_rej_pulse;
    logic [OCC_W-1:0] r_occ;

    state_e           w_next_state;
    cmd_e             w_next_cmd;
    cmd_e             w_cmd_in;
    logic             w_next_rej;
    logic             w_load;
    logic             w_expired;
    logic             w_reject;
    logic             w_release;
    logic             w_inc;
    logic             w_dec;
    logic [1:0]       w_pattern;

    phase_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .expired(w_expired)
    );

    assign w_cmd_in = cmd_e'(cmd);
    assign w_reject = ((w_cmd_in == CMD_ENTER) && (r_occ == OCC_W'(MAX_CARS))) ||
                      ((w_cmd_in == CMD_EXIT)  && (r_occ == '0));

    always_comb begin
        w_next_state = r_state;
        w_next_cmd   = r_cmd;
        w_next_rej   = r_rejected;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_next_cmd = w_cmd_in;
                    w_next_rej = w_reject;
                    if (w_reject) begin
                        w_next_state = ST_RELEASE;
                    end else begin
                        w_next_state = ST_PH1;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_PH1: begin
                if (w_expired) begin
                    w_next_state = ST_PH2;
                    w_load       = 1'b1;
                end
            end
            ST_PH2: begin
                if (w_expired) begin
                    w_next_state = ST_PH3;
                    w_load       = 1'b1;
                end
            end
            ST_PH3: begin
                if (w_expired) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_next_state = ST_IDLE;
                w_next_rej   = 1'b0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_rej   = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign w_release = (w_next_state == ST_RELEASE);
    assign w_inc     = w_release && !w_next_rej && (w_next_cmd == CMD_ENTER);
    assign w_dec     = w_release && !w_next_rej && (w_next_cmd == CMD_EXIT);
    assign w_pattern = sensor_pattern(w_next_state, w_next_cmd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= CMD_GAP;
            r_rejected  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_sensor_a  <= 1'b0;
            r_sensor_b  <= 1'b0;
            r_inc       <= 1'b0;
            r_dec       <= 1'b0;
            r_rej_pulse <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cmd       <= w_next_cmd;
            r_rejected  <= w_next_rej;
            r_cmd_ready <= (w_next_state == ST_IDLE);
            r_sensor_a  <= w_pattern[1];
            r_sensor_b  <= w_pattern[0];
            r_inc       <= w_inc;
            r_dec       <= w_dec;
            r_rej_pulse <= w_release && w_next_rej;
            if (w_inc) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_dec) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign sensor_a     = r_sensor_a;
    assign sensor_b     = r_sensor_b;
    assign inc_exp      = r_inc;
    assign dec_exp      = r_dec;
    assign cmd_rejected = r_rej_pulse;
    assign occ_count    = r_occ;

endmodule
